// File: rtl/mem_ctrl.sv
// mem_ctrl: sequencer for the single byte-wide RAM/IO port shared by instruction
// fetch (IF) and the load/store buffer (SLB). Multi-byte requests become one byte
// access per cycle; read bytes are assembled little-endian.
// Build macro MEM_CTRL_RR_ARB_EN: when defined, simultaneous requests are arbitrated
// round-robin (last-granted requester loses the tie, IF counts as last after reset);
// when undefined, the SLB wins every tie.
module mem_ctrl #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_rdata,
    input  logic                  slb_req,
    input  logic                  slb_wr,
    input  logic [1:0]            slb_size,
    input  logic [ADDR_WIDTH-1:0] slb_addr,
    input  logic [31:0]           slb_wdata,
    output logic                  slb_done,
    output logic [31:0]           slb_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        SLB_RD,
        SLB_WR
    } state_t;

    state_t state;
    state_t next_state;

    // Attributes of the granted transaction
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [2:0]            cur_n;
    logic [31:0]           cur_wdata;

    // Progress counters: bytes put on the bus and bytes captured from mem_din
    logic [2:0]            issue_cnt;
    logic [2:0]            recv_cnt;
    logic [2:0]            recv_total;

    // pipe1: a read address is on mem_a this cycle; pipe2: its byte is on mem_din
    logic                  pipe1;
    logic                  pipe2;
    logic [31:0]           acc;
    logic [31:0]           acc_next;

    logic                  if_ok;
    logic                  slb_ok;
    logic                  pick_if;
    logic                  pick_slb;
    logic                  grant_if;
    logic                  grant_slb;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic                  iss_wr;
    logic [7:0]            iss_byte;
    logic [7:0]            cur_byte;
    logic                  capture;
    logic                  read_complete;
    logic                  finish;
    logic                  abort;
    logic                  cur_io;
    logic                  slb_io;

`ifdef MEM_CTRL_RR_ARB_EN
    logic                  last_if;
`endif

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign busy          = (state != IDLE);
    assign cur_io        = (cur_addr[17:16] == IO_SEL);
    assign slb_io        = (slb_addr[17:16] == IO_SEL);
    assign capture       = pipe2 && ((state == IF_RD) || (state == SLB_RD));
    assign recv_total    = recv_cnt + {2'b00, capture};
    assign read_complete = (recv_total == cur_n);

    // Decide who may be granted; a requester whose done pulse is showing is not re-granted
    always_comb begin
        if_ok  = if_req && !if_done && !flush;
        slb_ok = slb_req && !slb_done;
`ifdef MEM_CTRL_RR_ARB_EN
        pick_slb = slb_ok && (!if_ok || last_if);
`else
        pick_slb = slb_ok;
`endif
        pick_if = if_ok && !pick_slb;
    end

    // Select the store byte for the next issue and merge a captured byte into its lane
    always_comb begin
        case (issue_cnt[1:0])
            2'd0:    cur_byte = cur_wdata[7:0];
            2'd1:    cur_byte = cur_wdata[15:8];
            2'd2:    cur_byte = cur_wdata[23:16];
            default: cur_byte = cur_wdata[31:24];
        endcase
        acc_next = acc;
        if (capture) begin
            case (recv_cnt[1:0])
                2'd0:    acc_next[7:0]   = mem_din;
                2'd1:    acc_next[15:8]  = mem_din;
                2'd2:    acc_next[23:16] = mem_din;
                default: acc_next[31:24] = mem_din;
            endcase
        end
    end

    // Next-state logic: grants, byte issue, completion and fetch abort
    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_slb  = 1'b0;
        issue      = 1'b0;
        iss_addr   = '0;
        iss_wr     = 1'b0;
        iss_byte   = 8'd0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (rdy_in) begin
                    if (pick_slb) begin
                        grant_slb  = 1'b1;
                        next_state = slb_wr ? SLB_WR : SLB_RD;
                        iss_addr   = slb_addr;
                        iss_wr     = slb_wr;
                        iss_byte   = slb_wdata[7:0];
                        issue      = !(slb_wr && slb_io && io_buffer_full);
                    end else if (pick_if) begin
                        grant_if   = 1'b1;
                        next_state = IF_RD;
                        iss_addr   = if_addr;
                        issue      = 1'b1;
                    end
                end
            end
            IF_RD, SLB_RD: begin
                if ((state == IF_RD) && flush) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (rdy_in) begin
                    if (read_complete) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end else if (issue_cnt < cur_n) begin
                        issue    = 1'b1;
                        iss_addr = cur_addr + ADDR_WIDTH'(issue_cnt);
                    end
                end
            end
            SLB_WR: begin
                if (rdy_in) begin
                    if (issue_cnt == cur_n) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end else if (!(cur_io && io_buffer_full)) begin
                        issue    = 1'b1;
                        iss_wr   = 1'b1;
                        iss_addr = cur_addr + ADDR_WIDTH'(issue_cnt);
                        iss_byte = cur_byte;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

`ifdef MEM_CTRL_RR_ARB_EN
    // Remember who was granted last so the other side wins the next tie
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_if <= 1'b1;
        end else if (grant_if) begin
            last_if <= 1'b1;
        end else if (grant_slb) begin
            last_if <= 1'b0;
        end
    end
`endif

    // Registered memory port: address/data only on issuing edges, zero otherwise
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_a    <= '0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            pipe1    <= 1'b0;
            pipe2    <= 1'b0;
        end else begin
            mem_a    <= issue ? iss_addr : '0;
            mem_dout <= (issue && iss_wr) ? iss_byte : 8'd0;
            mem_wr   <= issue && iss_wr;
            pipe1    <= issue && !iss_wr;
            pipe2    <= pipe1 && !abort;
        end
    end

    // Transaction bookkeeping, read assembly and done pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cur_addr  <= '0;
            cur_n     <= 3'd0;
            cur_wdata <= 32'd0;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            acc       <= 32'd0;
            if_done   <= 1'b0;
            slb_done  <= 1'b0;
            if_rdata  <= 32'd0;
            slb_rdata <= 32'd0;
        end else begin
            if_done  <= 1'b0;
            slb_done <= 1'b0;
            if (grant_slb || grant_if) begin
                cur_addr  <= grant_slb ? slb_addr : if_addr;
                cur_n     <= grant_slb ? size_to_bytes(slb_size) : 3'd4;
                cur_wdata <= grant_slb ? slb_wdata : 32'd0;
                issue_cnt <= issue ? 3'd1 : 3'd0;
                recv_cnt  <= 3'd0;
                acc       <= 32'd0;
            end else if (abort) begin
                issue_cnt <= 3'd0;
                recv_cnt  <= 3'd0;
                acc       <= 32'd0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + 3'd1;
                end
                if (capture) begin
                    recv_cnt <= recv_total;
                    acc      <= acc_next;
                end
                if (finish) begin
                    case (state)
                        IF_RD: begin
                            if_done  <= 1'b1;
                            if_rdata <= acc_next;
                        end
                        SLB_RD: begin
                            slb_done  <= 1'b1;
                            slb_rdata <= acc_next;
                        end
                        default: slb_done <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule
